// File: rtl/tex_coord_wrap_pipe.sv
// tex_coord_wrap_pipe: float texture coords -> wrapped normalised coord, texel index and bilinear weight
// Three register stages (decode/shift, wrap, scale) under a single global stall.
module tex_coord_wrap_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 15,
    parameter int FRAC_W = 15,
    parameter int DIM_W  = 12,
    parameter int WGT_W  = 8
) (
    input  logic                           core_clock_i,
    input  logic                           core_reset_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [1:0]                     wrap_s_mode_i,
    input  logic [1:0]                     wrap_t_mode_i,
    input  logic [$clog2(DIM_W+1)-1:0]     log2_w_i,
    input  logic [$clog2(DIM_W+1)-1:0]     log2_h_i,
    input  logic [EXP_W+MANT_W:0]          tex_s_i,
    input  logic [EXP_W+MANT_W:0]          tex_t_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [FRAC_W-1:0]              coord_s_o,
    output logic [FRAC_W-1:0]              coord_t_o,
    output logic [DIM_W-1:0]               texel_s_o,
    output logic [DIM_W-1:0]               texel_t_o,
    output logic [WGT_W-1:0]               weight_s_o,
    output logic [WGT_W-1:0]               weight_t_o,
    output logic                           border_o
);
    localparam int FW   = 1 + EXP_W + MANT_W;
    localparam int LW   = $clog2(DIM_W + 1);
    localparam int FX   = DIM_W + 2 + FRAC_W;
    localparam int XW   = FX + MANT_W + 1;
    localparam int PW   = FRAC_W + DIM_W;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;

    typedef struct packed {
        logic              neg;
        logic              n0;
        logic              nz;
        logic [FRAC_W-1:0] f;
    } dec_t;

    typedef struct packed {
        logic              border;
        logic [FRAC_W-1:0] coord;
    } wrap_t;

    typedef struct packed {
        logic [DIM_W-1:0] texel;
        logic [WGT_W-1:0] weight;
    } scale_t;

    typedef struct packed {
        dec_t          s;
        dec_t          t;
        logic [1:0]    ms;
        logic [1:0]    mt;
        logic [LW-1:0] lw;
        logic [LW-1:0] lh;
    } st1_t;

    typedef struct packed {
        wrap_t         s;
        wrap_t         t;
        logic [LW-1:0] lw;
        logic [LW-1:0] lh;
    } st2_t;

    typedef struct packed {
        logic [FRAC_W-1:0] coord_s;
        logic [FRAC_W-1:0] coord_t;
        scale_t            s;
        scale_t            t;
        logic              border;
    } st3_t;

    // Only the fraction, the integer LSB and integer!=0 are needed downstream.
    function automatic dec_t decode(input logic [FW-1:0] x);
        logic [EXP_W-1:0] e;
        logic [XW-1:0]    m;
        logic [FX-1:0]    fx;
        int               sh;
        dec_t             r;
        e     = x[FW-2 -: EXP_W];
        m     = XW'({1'b1, x[MANT_W-1:0]});
        sh    = int'(e) - BIAS - MANT_W + FRAC_W;
        fx    = (e == '0) ? '0 : (sh >= 0) ? FX'(m << sh) : FX'(m >> (-sh));
        r.neg = x[FW-1] && (e != '0);
        r.n0  = fx[FRAC_W];
        r.nz  = fx[FX-1:FRAC_W] != '0;
        r.f   = fx[FRAC_W-1:0];
        return r;
    endfunction

    function automatic wrap_t wrap(input dec_t d, input logic [1:0] mode);
        logic [FRAC_W-1:0] inv;
        wrap_t             r;
        inv      = -d.f;
        r.border = (mode == 2'd3) && (d.neg || d.nz);
        r.coord  = (mode == 2'd0) ? (d.neg ? inv : d.f) :
                   (mode == 2'd2) ? ((d.n0 ^ d.neg) ? inv : d.f) :
                   (d.neg || ((mode == 2'd3) && d.nz)) ? '0 :
                   d.nz ? '1 : d.f;
        return r;
    endfunction

    function automatic scale_t scale(input logic [FRAC_W-1:0] c, input logic [LW-1:0] l);
        logic [PW-1:0]           p;
        logic [DIM_W-1:0]        mask;
        logic [FRAC_W+WGT_W-1:0] wx;
        scale_t                  r;
        p        = PW'(c) << l;
        mask     = ~({DIM_W{1'b1}} << l);
        wx       = {p[FRAC_W-1:0], {WGT_W{1'b0}}};
        r.texel  = p[FRAC_W +: DIM_W] & mask;
        r.weight = wx[FRAC_W+WGT_W-1 -: WGT_W];
        return r;
    endfunction

    logic advance;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    st1_t s1_q, s1_d;
    st2_t s2_q, s2_d;
    st3_t s3_q, s3_d;

    // Data registers load only with valid beats so outputs stay 0 after reset until the first result.
    always_comb begin
        advance = !v3_q || out_ready_i;
        v1_d    = advance ? in_valid_i : v1_q;
        v2_d    = advance ? v1_q : v2_q;
        v3_d    = advance ? v2_q : v3_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        if (advance && in_valid_i) begin
            s1_d.s  = decode(tex_s_i);
            s1_d.t  = decode(tex_t_i);
            s1_d.ms = wrap_s_mode_i;
            s1_d.mt = wrap_t_mode_i;
            s1_d.lw = log2_w_i;
            s1_d.lh = log2_h_i;
        end
        if (advance && v1_q) begin
            s2_d.s  = wrap(s1_q.s, s1_q.ms);
            s2_d.t  = wrap(s1_q.t, s1_q.mt);
            s2_d.lw = s1_q.lw;
            s2_d.lh = s1_q.lh;
        end
        if (advance && v2_q) begin
            s3_d.coord_s = s2_q.s.coord;
            s3_d.coord_t = s2_q.t.coord;
            s3_d.s       = scale(s2_q.s.coord, s2_q.lw);
            s3_d.t       = scale(s2_q.t.coord, s2_q.lh);
            s3_d.border  = s2_q.s.border || s2_q.t.border;
        end
    end

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign in_ready_o  = advance;
    assign out_valid_o = v3_q;
    assign coord_s_o   = s3_q.coord_s;
    assign coord_t_o   = s3_q.coord_t;
    assign texel_s_o   = s3_q.s.texel;
    assign texel_t_o   = s3_q.t.texel;
    assign weight_s_o  = s3_q.s.weight;
    assign weight_t_o  = s3_q.t.weight;
    assign border_o    = s3_q.border;
endmodule

// File: tb/tb_tex_coord_wrap_pipe.sv
// tb_tex_coord_wrap_pipe: directed vector table plus stall, stream-order and reset-flush sequences
module tb_tex_coord_wrap_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, border;
    logic [1:0]  ms, mt;
    logic [3:0]  lw, lh;
    logic [23:0] s, t;
    logic [14:0] cs, ct;
    logic [11:0] xs, xt;
    logic [7:0]  ws, wt;

    tex_coord_wrap_pipe dut (
        .core_clock_i(clk), .core_reset_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .wrap_s_mode_i(ms), .wrap_t_mode_i(mt),
        .log2_w_i(lw), .log2_h_i(lh),
        .tex_s_i(s), .tex_t_i(t),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .coord_s_o(cs), .coord_t_o(ct),
        .texel_s_o(xs), .texel_t_o(xt),
        .weight_s_o(ws), .weight_t_o(wt),
        .border_o(border)
    );

    localparam logic [1:0] R = 2'd0, C = 2'd1, M = 2'd2, B = 2'd3;
    localparam logic [23:0] P025 = {1'b0, 8'd125, 15'h0000};
    localparam logic [23:0] N025 = {1'b1, 8'd125, 15'h0000};
    localparam logic [23:0] P0125 = {1'b0, 8'd124, 15'h0000};
    localparam logic [23:0] P05  = {1'b0, 8'd126, 15'h0000};
    localparam logic [23:0] P125 = {1'b0, 8'd127, 15'h2000};
    localparam logic [23:0] N125 = {1'b1, 8'd127, 15'h2000};
    localparam logic [23:0] N100 = {1'b1, 8'd127, 15'h0000};
    localparam logic [23:0] P150 = {1'b0, 8'd127, 15'h4000};
    localparam logic [23:0] P225 = {1'b0, 8'd128, 15'h1000};
    localparam logic [23:0] N300 = {1'b1, 8'd128, 15'h4000};
    localparam logic [23:0] P01  = {1'b0, 8'd123, 15'h4CCD};
    localparam logic [23:0] N01  = {1'b1, 8'd123, 15'h4CCD};
    localparam logic [23:0] NZ   = {1'b1, 8'd0,   15'h1234};
    localparam logic [23:0] BIG  = {1'b0, 8'd255, 15'h0000};

    typedef struct {
        logic [23:0] s, t;
        logic [1:0]  ms, mt;
        logic [3:0]  lw, lh;
        logic [14:0] cs, ct;
        logic [11:0] xs, xt;
        logic [7:0]  ws, wt;
        logic        b;
    } vec_t;

    vec_t        vecs[10];
    logic [23:0] sp[6];
    logic [14:0] se[6];
    logic [14:0] got[$];
    logic        mon_en = 1'b0;
    int          errors = 0, checks = 0;

    always @(negedge clk) if (mon_en && out_valid && out_ready) got.push_back(cs);

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int n;
        s = v.s; t = v.t; ms = v.ms; mt = v.mt; lw = v.lw; lh = v.lh;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d in_ready", k), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("v%0d latency", k), n, 3);
        chk($sformatf("v%0d coord_s", k), cs, v.cs);
        chk($sformatf("v%0d coord_t", k), ct, v.ct);
        chk($sformatf("v%0d texel_s", k), xs, v.xs);
        chk($sformatf("v%0d texel_t", k), xt, v.xt);
        chk($sformatf("v%0d weight_s", k), ws, v.ws);
        chk($sformatf("v%0d weight_t", k), wt, v.wt);
        chk($sformatf("v%0d border", k), border, v.b);
    endtask

    initial begin
        int sent, cyc, n;
        logic acc;
        vecs[0] = '{P025, P025, R, R, 4'd8, 4'd8,  15'h2000, 15'h2000, 12'd64,  12'd64,   8'h00, 8'h00, 1'b0};
        vecs[1] = '{N025, P125, R, M, 4'd8, 4'd8,  15'h6000, 15'h6000, 12'd192, 12'd192,  8'h00, 8'h00, 1'b0};
        vecs[2] = '{N100, P150, R, C, 4'd8, 4'd8,  15'h0000, 15'h7FFF, 12'd0,   12'd255,  8'h00, 8'hFE, 1'b0};
        vecs[3] = '{N300, P01,  C, R, 4'd8, 4'd4,  15'h0000, 15'h0CCC, 12'd0,   12'd1,    8'h00, 8'h99, 1'b0};
        vecs[4] = '{P05,  N01,  R, B, 4'd8, 4'd8,  15'h4000, 15'h0000, 12'd128, 12'd0,    8'h00, 8'h00, 1'b1};
        vecs[5] = '{NZ,   BIG,  B, C, 4'd8, 4'd8,  15'h0000, 15'h0000, 12'd0,   12'd0,    8'h00, 8'h00, 1'b0};
        vecs[6] = '{P225, N025, M, M, 4'd8, 4'd8,  15'h2000, 15'h6000, 12'd64,  12'd192,  8'h00, 8'h00, 1'b0};
        vecs[7] = '{N125, P025, M, R, 4'd0, 4'd12, 15'h2000, 15'h2000, 12'd0,   12'd1024, 8'h40, 8'h00, 1'b0};
        vecs[8] = '{P150, P025, B, B, 4'd8, 4'd8,  15'h0000, 15'h2000, 12'd0,   12'd64,   8'h00, 8'h00, 1'b1};
        vecs[9] = '{N025, P05,  R, M, 4'd0, 4'd12, 15'h6000, 15'h4000, 12'd0,   12'd2048, 8'hC0, 8'h00, 1'b0};
        sp = '{P025, N025, P05, P01, N01, P0125};
        se = '{15'h2000, 15'h6000, 15'h4000, 15'h0CCC, 15'h7334, 15'h1000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        s = '0; t = '0; ms = R; mt = R; lw = '0; lh = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset coord_s", cs, 0);
        chk("reset texel_t", xt, 0);
        chk("reset border", border, 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
        repeat (2) @(posedge clk);
        #1;

        // Six-pair stream with out_ready dropped for five cycles while pair 0 is presented.
        got.delete();
        mon_en = 1'b1;
        sent = 0; cyc = 0;
        t = P025; mt = R; ms = R; lw = 4'd8; lh = 4'd8;
        while (sent < 6 && cyc < 60) begin
            s = sp[sent];
            in_valid = 1'b1;
            out_ready = !(cyc >= 3 && cyc < 8);
            @(negedge clk);
            acc = in_ready;
            if (!out_ready) begin
                chk($sformatf("stall%0d out_valid", cyc), out_valid, 1);
                chk($sformatf("stall%0d in_ready", cyc), in_ready, 0);
                chk($sformatf("stall%0d coord_s", cyc), cs, se[0]);
            end
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream sent", sent, 6);
        n = 0;
        while (got.size() < 6 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1 mon_en = 1'b0;
        chk("stream count", got.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("stream%0d coord_s", i), (i < got.size()) ? got[i] : 15'h0, se[i]);

        // Reset with three pairs in flight: nothing may emerge.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = sp[i]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("flight out_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        chk("flush coord_s", cs, 0);
        got.delete();
        mon_en = 1'b1;
        repeat (6) @(posedge clk);
        #1 mon_en = 1'b0;
        chk("flush emitted", got.size(), 0);
        run_vec(vecs[1], 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
